led_pattern_monitor: RTL

Observer/decoder for the 16-bit holiday-lights LED bus: samples the `led` vector driven by the light generator and recovers the lit-segment length and head position. Checks that every change is a legal one-step left rotation or a legal reload, and flags errors and stalls. It sits beside the light generator on the same `led` bus and feeds status logic or a bench scoreboard; it never drives `led`.

---
 rtl/led_mon_pkg.sv | 16 +
 rtl/led_run_decode.sv | 31 +++
 rtl/led_pattern_monitor.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/led_mon_pkg.sv
// Shared types and constants for the LED bus pattern monitor.
// State encodings, LED width and default stall timeout.
package led_mon_pkg;

  localparam int LED_W = 16;

  localparam logic [31:0] STALL_DEFAULT = 32'd110_000_000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    ERROR   = 2'd3
  } state_t;

endpackage

// File: rtl/led_run_decode.sv
// Combinational decode of a 16-bit LED vector into run metrics.
// Ports: vec in; pop (lit count), head (run start), valid, zero out.
module led_run_decode
  import led_mon_pkg::*;
(
  input  logic [LED_W-1:0] vec,
  output logic [4:0]       pop,
  output logic [3:0]       head,
  output logic             valid,
  output logic             zero
);

  logic [4:0] starts;

  always_comb begin
    pop    = '0;
    starts = '0;
    head   = '0;
    for (int i = 0; i < LED_W; i++) begin
      pop = pop + 5'(vec[i]);
      if (vec[i] && !vec[(i + LED_W - 1) % LED_W]) begin
        starts = starts + 5'd1;
        head   = 4'(i);
      end
    end
  end

  assign zero  = (vec == '0);
  assign valid = (vec == '1) || (starts == 5'd1);

endmodule

// File: rtl/led_pattern_monitor.sv
// Passive monitor for the rotating LED bus: locks, errors, stalls.
// Ports: clk, rst (async low), led in; state, locked, lit_count,
// head_pos, err_pulse, stall, err_cnt out. Macro: LED_MON_ERRCNT_EN.
module led_pattern_monitor
  import led_mon_pkg::*;
#(
  parameter int          LOCK_STEPS   = 2,
  parameter logic [31:0] STALL_CYCLES = STALL_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LED_W-1:0] led,
  output logic [1:0]       state,
  output logic             locked,
  output logic [4:0]       lit_count,
  output logic [3:0]       head_pos,
  output logic             err_pulse,
  output logic             stall,
  output logic [7:0]       err_cnt
);

  localparam logic [4:0] LOCK_TH = 5'(LOCK_STEPS);

  state_t           st;
  logic [LED_W-1:0] led_q;
  logic [LED_W-1:0] led_p;
  logic [4:0]       pop_p;
  logic [3:0]       step;
  logic [31:0]      idle;

  logic [4:0] pop_q;
  logic [3:0] head_q;
  logic       valid_q;
  logic       zero_q;

  led_run_decode u_dec (
    .vec   (led_q),
    .pop   (pop_q),
    .head  (head_q),
    .valid (valid_q),
    .zero  (zero_q)
  );

  logic        chg;
  logic        legal;
  logic        first;
  logic        ok;
  logic        c_zero;
  logic        c_bad;
  logic        c_new;
  logic        c_step;
  logic        c_reload;
  logic        c_err;
  logic        err_set;
  logic [3:0]  step_nx;
  logic        lock_nx;
  logic [31:0] idle_nx;

  always_comb begin
    chg      = (led_q != led_p);
    legal    = (led_q == {led_p[LED_W-2:0], led_p[LED_W-1]});
    first    = (st == IDLE) || (st == ERROR);
    ok       = valid_q && !zero_q;
    c_zero   = zero_q;
    c_bad    = !zero_q && !valid_q;
    c_new    = ok && first;
    c_step   = ok && !first && legal;
    c_reload = ok && !first && !legal && (pop_q != pop_p);
    c_err    = ok && !first && !legal && (pop_q == pop_p);
    err_set  = chg && (c_bad || c_err);
    step_nx  = (step == 4'd15) ? step : step + 4'd1;
    lock_nx  = ({1'b0, step_nx} >= LOCK_TH);
    idle_nx  = (idle == '1) ? idle : idle + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      led_q     <= '0;
      led_p     <= '0;
      pop_p     <= '0;
      step      <= '0;
      idle      <= '0;
      lit_count <= '0;
      head_pos  <= '0;
      err_pulse <= 1'b0;
      stall     <= 1'b0;
    end else begin
      led_q     <= led;
      led_p     <= led_q;
      pop_p     <= pop_q;
      err_pulse <= err_set;
      if (chg) begin
        idle  <= '0;
        stall <= 1'b0;
        if (ok) begin
          lit_count <= pop_q;
          head_pos  <= head_q;
        end
        unique case (1'b1)
          c_zero: begin
            st        <= IDLE;
            step      <= '0;
            lit_count <= '0;
            head_pos  <= '0;
          end
          c_bad:    st <= ERROR;
          c_new: begin
            st   <= ACQUIRE;
            step <= '0;
          end
          c_step: begin
            step <= step_nx;
            st   <= lock_nx ? LOCKED : ACQUIRE;
          end
          c_reload: begin
            st   <= ACQUIRE;
            step <= '0;
          end
          c_err:    st <= ERROR;
        endcase
      end else if (st == LOCKED) begin
        idle <= idle_nx;
        // Timeout drops back to acquisition rather than ERROR.
        if (idle_nx == STALL_CYCLES) begin
          stall <= 1'b1;
          st    <= ACQUIRE;
          step  <= '0;
        end
      end
    end
  end

  assign state  = st;
  assign locked = (st == LOCKED);

`ifdef LED_MON_ERRCNT_EN
  logic [7:0] ecnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ecnt <= '0;
    end else if (err_set && (ecnt != 8'hFF)) begin
      ecnt <= ecnt + 8'd1;
    end
  end

  assign err_cnt = ecnt;
`else
  assign err_cnt = 8'd0;
`endif

endmodule
